hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage datapath (fetch, decode, execute, memory, write-back). It stalls decode on read-after-write hazards using a three-entry destination-register scoreboard, since there is no forwarding. It freezes fetch while a branch travels to the memory stage and flushes the wrongly fetched instruction when `pc_src` reports a taken branch. It also keeps saturating stall and flush counters for performance measurement.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_scoreboard.sv | 71 +++++++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and FSM encoding for the pipeline hazard controller.
package hazard_ctrl_pkg;

    // X31 reads as zero and discards writes, so it never creates a dependency.
    localparam int unsigned REG_XZR = 31;

    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_BR_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-stage {valid, rd} destination scoreboard (EX, MEM, WB) with match
// outputs for the two decode source registers.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push_valid,
    input  logic [REG_W-1:0] i_push_rd,
    input  logic [REG_W-1:0] i_rn,
    input  logic             i_uses_rn,
    input  logic [REG_W-1:0] i_rm,
    input  logic             i_uses_rm,
    output logic             o_match_rn,
    output logic             o_match_rm
);

    logic             r_valid_ex;
    logic             r_valid_mem;
    logic             r_valid_wb;
    logic [REG_W-1:0] r_rd_ex;
    logic [REG_W-1:0] r_rd_mem;
    logic [REG_W-1:0] r_rd_wb;

    // WB stays in the compare set: the register file cannot return a value written this cycle.
    function automatic logic src_match(
        input logic [REG_W-1:0] src,
        input logic             uses,
        input logic             v_ex,
        input logic [REG_W-1:0] rd_ex,
        input logic             v_mem,
        input logic [REG_W-1:0] rd_mem,
        input logic             v_wb,
        input logic [REG_W-1:0] rd_wb
    );
        logic hit;
        hit = (v_ex && (rd_ex == src)) || (v_mem && (rd_mem == src)) ||
              (v_wb && (rd_wb == src));
        return uses && (src != REG_W'(REG_XZR)) && hit;
    endfunction

    // Shift the in-flight destinations one stage per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_ex  <= 1'b0;
            r_valid_mem <= 1'b0;
            r_valid_wb  <= 1'b0;
            r_rd_ex     <= {REG_W{1'b0}};
            r_rd_mem    <= {REG_W{1'b0}};
            r_rd_wb     <= {REG_W{1'b0}};
        end else begin
            r_valid_ex  <= i_push_valid;
            r_valid_mem <= r_valid_ex;
            r_valid_wb  <= r_valid_mem;
            r_rd_ex     <= i_push_rd;
            r_rd_mem    <= r_rd_ex;
            r_rd_wb     <= r_rd_mem;
        end
    end

    // Compare both decode sources against every live entry.
    always_comb begin
        o_match_rn = src_match(i_rn, i_uses_rn, r_valid_ex, r_rd_ex,
                               r_valid_mem, r_rd_mem, r_valid_wb, r_rd_wb);
        o_match_rm = src_match(i_rm, i_uses_rm, r_valid_ex, r_rd_ex,
                               r_valid_mem, r_rd_mem, r_valid_wb, r_rd_wb);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: RAW stalls via the scoreboard,
// branch freeze/flush FSM and saturating performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_write_register,
    input  logic             id_branch,
    input  logic             pc_src,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hz_state_e        r_state;
    hz_state_e        w_next_state;
    hz_state_e        w_run_next;
    logic             r_br_cnt;
    logic             w_next_br_cnt;
    logic             w_match_rn;
    logic             w_match_rm;
    logic             w_hazard;
    logic             w_push_valid;
    logic             w_flush_evt;
    logic             w_proto_evt;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    hazard_scoreboard #(.REG_W(REG_W)) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (w_push_valid),
        .i_push_rd    (id_write_register),
        .i_rn         (id_rn),
        .i_uses_rn    (id_uses_rn),
        .i_rm         (id_rm),
        .i_uses_rm    (id_uses_rm),
        .o_match_rn   (w_match_rn),
        .o_match_rm   (w_match_rm)
    );

    // Normal-flow decisions shared by RUN and the not-taken resolve cycle.
    always_comb begin
        w_hazard     = id_valid && (w_match_rn || w_match_rm);
        w_run_next   = (!w_hazard && id_valid && id_branch) ? HZ_BR_WAIT : HZ_RUN;
        w_push_valid = id_valid && id_reg_write && !idex_bubble &&
                       (id_write_register != REG_W'(REG_XZR));
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_bubble   = 1'b0;
        flush_id      = 1'b0;
        w_next_state  = r_state;
        w_next_br_cnt = r_br_cnt;
        w_flush_evt   = 1'b0;
        w_proto_evt   = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_bubble   = 1'b1;
            flush_id      = 1'b1;
            w_next_state  = HZ_RUN;
            w_next_br_cnt = 1'b0;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    pc_write      = !w_hazard;
                    ifid_write    = !w_hazard;
                    idex_bubble   = w_hazard;
                    w_next_state  = w_run_next;
                    w_next_br_cnt = (w_run_next == HZ_BR_WAIT);
                    w_proto_evt   = pc_src;
                end
                HZ_BR_WAIT: begin
                    if (r_br_cnt) begin
                        // Branch still in EX: freeze fetch and decode.
                        pc_write      = 1'b0;
                        ifid_write    = 1'b0;
                        idex_bubble   = 1'b1;
                        w_next_br_cnt = 1'b0;
                        w_proto_evt   = pc_src;
                    end else if (pc_src) begin
                        pc_write     = 1'b1;
                        ifid_write   = 1'b0;
                        idex_bubble  = 1'b1;
                        flush_id     = 1'b1;
                        w_flush_evt  = 1'b1;
                        w_next_state = HZ_RUN;
                    end else begin
                        pc_write      = !w_hazard;
                        ifid_write    = !w_hazard;
                        idex_bubble   = w_hazard;
                        w_next_state  = w_run_next;
                        w_next_br_cnt = (w_run_next == HZ_BR_WAIT);
                    end
                end
                default: begin
                    w_next_state  = HZ_RUN;
                    w_next_br_cnt = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= HZ_RUN;
            r_br_cnt <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_br_cnt <= w_next_br_cnt;
        end
    end

    // Saturating performance counters and the sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
            r_proto_err <= 1'b0;
        end else begin
            if (idex_bubble && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
            if (w_proto_evt) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Counters read as zero for the whole reset window, including the first cycle.
    always_comb begin
        stall_cnt = reset ? {CNT_W{1'b0}} : r_stall_cnt;
        flush_cnt = reset ? {CNT_W{1'b0}} : r_flush_cnt;
        proto_err = reset ? 1'b0 : r_proto_err;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a tiny instruction front end plus a
// producer-age / branch-age model checked against the DUT every cycle.
module tb_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic             id_reg_write;
    logic [REG_W-1:0] id_write_register;
    logic             id_branch;
    logic             pc_src;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             flush_id;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             proto_err;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rn             (id_rn),
        .id_rm             (id_rm),
        .id_uses_rn        (id_uses_rn),
        .id_uses_rm        (id_uses_rm),
        .id_reg_write      (id_reg_write),
        .id_write_register (id_write_register),
        .id_branch         (id_branch),
        .pc_src            (pc_src),
        .pc_write          (pc_write),
        .ifid_write        (ifid_write),
        .idex_bubble       (idex_bubble),
        .flush_id          (flush_id),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt),
        .proto_err         (proto_err)
    );

    typedef struct {
        int rn; int rm; bit urn; bit urm; bit rw; int rd; bit br; bit tk;
    } ins_t;

    ins_t prog[$];
    int   errors = 0;
    int   checks = 0;
    int   n_bub_seen;
    int   n_flush_seen;
    bit   force_src;
    bit   cur_tk;

    // Model: producers still able to conflict, each with cycles since issue (1..3).
    int m_rd[$];
    int m_age[$];
    int m_br_age;   // 0 none, 1 branch in EX, 2 branch in MEM
    bit m_taken;
    bit m_err;
    int m_stall;
    int m_flush;
    bit e_pc, e_if, e_bub, e_fl, e_fevt, e_perr, e_issue;

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit src_hit(input int r, input bit used);
        if (!used || r == 31) return 1'b0;
        foreach (m_rd[i]) if (m_rd[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        bit hz;
        hz = id_valid && (src_hit(int'(id_rn), id_uses_rn) || src_hit(int'(id_rm), id_uses_rm));
        e_fl = 1'b0; e_fevt = 1'b0; e_perr = 1'b0; e_issue = 1'b0;
        if (reset) begin
            e_pc = 1'b0; e_if = 1'b0; e_bub = 1'b1; e_fl = 1'b1;
        end else if (m_br_age == 1) begin
            e_pc = 1'b0; e_if = 1'b0; e_bub = 1'b1; e_perr = pc_src;
        end else if (m_br_age == 2 && pc_src) begin
            e_pc = 1'b1; e_if = 1'b0; e_bub = 1'b1; e_fl = 1'b1; e_fevt = 1'b1;
        end else begin
            e_pc = !hz; e_if = !hz; e_bub = hz;
            e_issue = !hz && id_valid && id_branch;
            e_perr  = pc_src && (m_br_age != 2);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_rd.delete(); m_age.delete();
            m_br_age = 0; m_taken = 1'b0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            for (int i = m_age.size() - 1; i >= 0; i--) begin
                m_age[i]++;
                if (m_age[i] > 3) begin
                    m_age.delete(i); m_rd.delete(i);
                end
            end
            if (!e_bub && id_valid && id_reg_write && int'(id_write_register) != 31) begin
                m_rd.push_back(int'(id_write_register)); m_age.push_back(1);
            end
            m_br_age = (m_br_age == 1) ? 2 : (e_issue ? 1 : 0);
            if (e_issue) m_taken = cur_tk;
            if (e_bub && m_stall < CNT_MAX) m_stall++;
            if (e_fevt && m_flush < CNT_MAX) m_flush++;
            if (e_perr) m_err = 1'b1;
        end
    endtask

    // One clock cycle: predict, compare at negedge, advance the model at posedge.
    task automatic step();
        model_eval();
        @(negedge clk);
        chk("pc_write", pc_write, e_pc);
        chk("ifid_write", ifid_write, e_if);
        chk("idex_bubble", idex_bubble, e_bub);
        chk("flush_id", flush_id, e_fl);
        chk("stall_cnt", stall_cnt, reset ? 0 : m_stall);
        chk("flush_cnt", flush_cnt, reset ? 0 : m_flush);
        chk("proto_err", proto_err, reset ? 0 : m_err);
        if (!reset && idex_bubble === 1'b1) n_bub_seen++;
        if (!reset && flush_id === 1'b1) n_flush_seen++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        id_reg_write = 1'b0; id_write_register = '0; id_branch = 1'b0; cur_tk = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; pc_src = 1'b0;
        idle_inputs();
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic add(input int rn, input int rm, input bit urn, input bit urm,
                       input bit rw, input int rd, input bit br, input bit tk);
        ins_t t;
        t.rn = rn; t.rm = rm; t.urn = urn; t.urm = urm;
        t.rw = rw; t.rd = rd; t.br = br; t.tk = tk;
        prog.push_back(t);
    endtask

    // Front end: IF/ID holds prog[idx]; a flush skips the wrong-path slot and leaves one empty cycle.
    task automatic run_prog(input int n);
        int idx;
        bit nop;
        idx = 0; nop = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (!nop && idx < prog.size()) begin
                id_valid = 1'b1;
                id_rn = REG_W'(prog[idx].rn); id_rm = REG_W'(prog[idx].rm);
                id_uses_rn = prog[idx].urn; id_uses_rm = prog[idx].urm;
                id_reg_write = prog[idx].rw; id_write_register = REG_W'(prog[idx].rd);
                id_branch = prog[idx].br; cur_tk = prog[idx].tk;
            end else begin
                idle_inputs();
            end
            pc_src = force_src || (m_br_age == 2 && m_taken);
            step();
            if (e_fevt) begin
                nop = 1'b1; idx++;
            end else if (nop) begin
                if (e_if) nop = 1'b0;
            end else if (e_if && idx < prog.size()) begin
                idx++;
            end
        end
        pc_src = 1'b0;
        idle_inputs();
    endtask

    task automatic new_test();
        prog.delete(); n_bub_seen = 0; n_flush_seen = 0;
    endtask

    initial begin
        reset = 1'b1; pc_src = 1'b0; force_src = 1'b0;
        idle_inputs();
        m_br_age = 0; m_taken = 1'b0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        do_reset(2);

        // ADD X1 ; SUB X2,X1,X3
        new_test();
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(1, 3, 1, 1, 1, 2, 0, 0);
        run_prog(8);
        chk("b2b_stall_cnt", stall_cnt, 3);
        chk("b2b_bubbles", n_bub_seen, 3);

        // Writer of X31 followed by readers of X31
        do_reset(1); new_test();
        add(0, 0, 0, 0, 1, 31, 0, 0);
        add(31, 31, 1, 1, 1, 4, 0, 0);
        add(31, 0, 1, 0, 0, 0, 0, 0);
        run_prog(6);
        chk("xzr_stall_cnt", stall_cnt, 0);

        // Taken B: wrong-path ADD X7 is flushed, target ADD X8 follows
        do_reset(1); new_test();
        add(0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 7, 0, 0);
        add(0, 0, 0, 0, 1, 8, 0, 0);
        run_prog(8);
        chk("taken_flush_cnt", flush_cnt, 1);
        chk("taken_stall_cnt", stall_cnt, 2);
        chk("taken_flush_cycles", n_flush_seen, 1);

        // Not-taken CBZ X9
        do_reset(1); new_test();
        add(9, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0);
        run_prog(6);
        chk("nt_stall_cnt", stall_cnt, 1);
        chk("nt_flush_cnt", flush_cnt, 0);
        chk("nt_flush_cycles", n_flush_seen, 0);

        // ADD X5 ; CBZ X5 (not taken) ; ADD
        do_reset(1); new_test();
        add(0, 0, 0, 0, 1, 5, 0, 0);
        add(5, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 6, 0, 0);
        run_prog(10);
        chk("hzbr_stall_cnt", stall_cnt, 4);

        // Stray pc_src in RUN, held afterwards
        do_reset(1); new_test();
        force_src = 1'b1; run_prog(1); force_src = 1'b0;
        run_prog(3);
        chk("proto_err_set", proto_err, 1);

        // Reset while a branch waits in BR_WAIT (proto_err still set from above)
        new_test();
        add(0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 7, 0, 0);
        run_prog(2);
        do_reset(1); new_test();
        run_prog(3);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_flush_cycles", n_flush_seen, 0);

        // Dependency chain X1->X2->...->X7: 18 bubbles saturate a 4-bit counter
        do_reset(1); new_test();
        add(0, 0, 0, 0, 1, 1, 0, 0);
        for (int r = 2; r <= 7; r++) add(r - 1, 0, 1, 0, 1, r, 0, 0);
        run_prog(35);
        chk("sat_stall_cnt", stall_cnt, CNT_MAX);

        // 17 taken branches saturate the flush counter
        do_reset(1); new_test();
        for (int b = 0; b < 17; b++) begin
            add(0, 0, 0, 0, 0, 0, 1, 1);
            add(0, 0, 0, 0, 1, 7, 0, 0);
        end
        run_prog(80);
        chk("sat_flush_cnt", flush_cnt, CNT_MAX);
        chk("sat_flush_cycles", n_flush_seen, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
